// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, FSM states, latencies.
package md_sequencer_pkg;

  typedef enum logic [2:0] {
    OpMult  = 3'b000,
    OpMultu = 3'b001,
    OpDiv   = 3'b010,
    OpDivu  = 3'b011,
    OpMthi  = 3'b100,
    OpMtlo  = 3'b101
  } md_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam int unsigned MultCyclesDefault = 5;
  localparam int unsigned DivCyclesDefault  = 10;
  localparam int unsigned CntW              = 4;

  // MULT, MULTU, DIV and DIVU all have md_op[2] clear.
  function automatic logic is_muldiv(logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// E/D-stage request and HI/LO/busy/stall result bundle for the MD sequencer.
interface md_sequencer_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        d_is_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  modport master (
    output start, md_op, opa, opb, d_is_md,
    input  hi, lo, busy, stall
  );

  modport slave (
    input  start, md_op, opa, opb, d_is_md,
    output hi, lo, busy, stall
  );
endinterface

// File: rtl/md_sequencer_arith.sv
// Combinational 64-bit multiply / 32-bit divide datapath on the latched operands.
module md_arith
  import md_sequencer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic        is_signed;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_b;
  logic [31:0] uq;
  logic [31:0] ur;

  assign is_signed = (op == OpMult) || (op == OpDiv);
  assign div_zero  = ((op == OpDiv) || (op == OpDivu)) && (b == 32'd0);

  // Low 64 bits of the 64x64 product of extended operands serve both signednesses.
  assign ext_a = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
  assign ext_b = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
  assign prod  = ext_a * ext_b;

  // One unsigned divider on magnitudes; signs are restored afterwards so that
  // 0x80000000 / -1 cannot overflow and the quotient truncates toward zero.
  assign mag_a = (is_signed && a[31]) ? (32'd0 - a) : a;
  assign mag_b = (is_signed && b[31]) ? (32'd0 - b) : b;
  assign div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign uq    = mag_a / div_b;
  assign ur    = mag_a % div_b;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      OpMult, OpMultu: begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      OpDiv: begin
        res_lo = (a[31] ^ b[31]) ? (32'd0 - uq) : uq;
        res_hi = a[31] ? (32'd0 - ur) : ur;
      end
      OpDivu: begin
        res_lo = uq;
        res_hi = ur;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// MIPS-style HI/LO multiply/divide sequencer: fixed-latency FSM, HI/LO registers, D-stage stall.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDefault,
  parameter int unsigned DIV_CYCLES  = DivCyclesDefault
) (
  input  logic           clk,
  input  logic           reset,
  md_sequencer_if.slave  md
);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  logic [31:0]       res_hi;
  logic [31:0]       res_lo;
  logic              div_zero;

  md_arith u_arith (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (md.start) begin
          case (md.md_op)
            OpMult, OpMultu, OpDiv, OpDivu: begin
              op_d    = md.md_op;
              a_d     = md.opa;
              b_d     = md.opb;
              cnt_d   = is_muldiv(md.md_op) && !md.md_op[1] ? CntW'(MULT_CYCLES - 1)
                                                             : CntW'(DIV_CYCLES - 1);
              state_d = StRun;
            end
            OpMthi:  hi_d = md.opa;
            OpMtlo:  lo_d = md.opa;
            default: ;
          endcase
        end
      end
      StRun: begin
        // A start seen here is deliberately ignored; the latched operation finishes first.
        if (cnt_q == '0) begin
          state_d = StIdle;
          if (!div_zero) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.hi    = hi_q;
  assign md.lo    = lo_q;
  assign md.busy  = (state_q == StRun);
  assign md.stall = md.d_is_md & (md.busy | (md.start & is_muldiv(md.md_op)));

endmodule

// File: tb/tb_md_sequencer.sv
// Directed plus random checks of md_sequencer against an arithmetic reference model.
module tb_md_sequencer;
  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference state: architectural HI/LO, remaining busy cycles, pending result.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;
  int          m_rem = 0;
  bit          m_dz = 1'b0;

  md_sequencer_if ifc ();

  md_sequencer #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check stall, update model at posedge, check state at next negedge.
  task automatic step(input bit rst, input bit st, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b, input bit dmd);
    longint          sa, sb, sp;
    longint unsigned up;
    bit              exp_stall;
    reset       = rst;
    ifc.start   = st;
    ifc.md_op   = op;
    ifc.opa     = a;
    ifc.opb     = b;
    ifc.d_is_md = dmd;
    #1;
    exp_stall = dmd && ((m_rem > 0) || (st && (op < 3'd4)));
    chk("stall", {31'd0, ifc.stall}, {31'd0, exp_stall});
    @(posedge clk);
    if (rst) begin
      m_hi = '0; m_lo = '0; m_rem = 0; m_dz = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && !m_dz) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (st) begin
      case (op)
        3'd0: begin
          sa = $signed(a); sb = $signed(b); sp = sa * sb;
          p_hi = sp[63:32]; p_lo = sp[31:0];
        end
        3'd1: begin
          up = longint'(a) * longint'(b);
          p_hi = up[63:32]; p_lo = up[31:0];
        end
        3'd2: begin
          if (b != 0) begin
            sa = $signed(a); sb = $signed(b);
            sp = sa / sb; p_lo = sp[31:0];
            sp = sa % sb; p_hi = sp[31:0];
          end
        end
        3'd3: begin
          if (b != 0) begin
            p_lo = a / b; p_hi = a % b;
          end
        end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
      if (op < 3'd4) begin
        m_rem = (op < 3'd2) ? MC : DC;
        m_dz  = (op >= 3'd2) && (b == 0);
      end
    end
    @(negedge clk);
    chk("busy", {31'd0, ifc.busy}, {31'd0, (m_rem > 0)});
    chk("hi", ifc.hi, m_hi);
    chk("lo", ifc.lo, m_lo);
  endtask

  task automatic idle(input int n, input bit dmd);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd7, '0, '0, dmd);
  endtask

  initial begin
    reset = 1'b1;
    ifc.start = 1'b0; ifc.md_op = '0; ifc.opa = '0; ifc.opb = '0; ifc.d_is_md = 1'b0;
    @(negedge clk);

    step(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
    step(1'b1, 1'b1, 3'd4, 32'h5, '0, 1'b0);
    chk("rst_busy", {31'd0, ifc.busy}, 32'd0);
    chk("rst_hi", ifc.hi, 32'd0);
    chk("rst_lo", ifc.lo, 32'd0);

    // MULT 3 * -2
    step(1'b0, 1'b1, 3'd0, 32'd3, 32'hFFFF_FFFE, 1'b1);
    idle(MC, 1'b0);
    chk("mult_hi", ifc.hi, 32'hFFFF_FFFF);
    chk("mult_lo", ifc.lo, 32'hFFFF_FFFA);

    // DIVU 7/2 and DIV -7/2
    step(1'b0, 1'b1, 3'd3, 32'd7, 32'd2, 1'b0);
    idle(DC, 1'b1);
    chk("divu_lo", ifc.lo, 32'd3);
    chk("divu_hi", ifc.hi, 32'd1);
    step(1'b0, 1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(DC, 1'b0);
    chk("div_lo", ifc.lo, 32'hFFFF_FFFD);
    chk("div_hi", ifc.hi, 32'hFFFF_FFFF);

    // Divide by zero keeps HI/LO
    step(1'b0, 1'b1, 3'd4, 32'h11, '0, 1'b0);
    step(1'b0, 1'b1, 3'd5, 32'h22, '0, 1'b0);
    step(1'b0, 1'b1, 3'd2, 32'd1234, 32'd0, 1'b0);
    idle(DC, 1'b0);
    chk("dz_hi", ifc.hi, 32'h11);
    chk("dz_lo", ifc.lo, 32'h22);

    // Second start during RUN is ignored; stall held throughout
    step(1'b0, 1'b1, 3'd0, 32'd4, 32'd5, 1'b1);
    idle(1, 1'b1);
    step(1'b0, 1'b1, 3'd0, 32'd7, 32'd7, 1'b1);
    idle(MC - 2, 1'b1);
    chk("ign_hi", ifc.hi, 32'd0);
    chk("ign_lo", ifc.lo, 32'd20);
    idle(2, 1'b0);
    chk("ign_lo2", ifc.lo, 32'd20);

    // Reset on third busy cycle of DIV, also dominating a start
    step(1'b0, 1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 1'b1, 3'd0, 32'd9, 32'd9, 1'b0);
    chk("abort_busy", {31'd0, ifc.busy}, 32'd0);
    chk("abort_hi", ifc.hi, 32'd0);
    chk("abort_lo", ifc.lo, 32'd0);
    idle(DC + 2, 1'b0);
    chk("abort_lo2", ifc.lo, 32'd0);

    // MTHI while IDLE, undefined ops
    step(1'b0, 1'b1, 3'd4, 32'hDEAD_BEEF, '0, 1'b0);
    chk("mthi_hi", ifc.hi, 32'hDEAD_BEEF);
    chk("mthi_stall", {31'd0, ifc.stall}, 32'd0);
    step(1'b0, 1'b1, 3'd6, 32'h1, 32'h2, 1'b1);
    step(1'b0, 1'b1, 3'd7, 32'h3, 32'h4, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rb;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
           3'($urandom_range(0, 7)), $urandom, rb, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
